id_scoreboard: RTL

ID_SCOREBOARD -- requirements
Module: id_scoreboard

---
 rtl/id_scoreboard_if.sv | 30 +++
 rtl/id_scoreboard.sv | 53 +++++
 2 files changed

// File: rtl/id_scoreboard_if.sv
// id_scoreboard_if: decode/writeback handshake bundle between the pipeline and the register scoreboard.
interface id_scoreboard_if;
   logic        id_valid_i;
   logic        id_reg1_re_i;
   logic        id_reg2_re_i;
   logic [4:0]  id_reg1_addr_i;
   logic [4:0]  id_reg2_addr_i;
   logic        id_we_i;
   logic [4:0]  id_waddr_i;
   logic        retire_i;
   logic        wb_we_i;
   logic [4:0]  wb_waddr_i;
   logic        flush_i;
   logic        drain_req_i;
   logic        issue_o;
   logic        stall_id_o;
   logic        drain_done_o;
   logic [31:0] pending_o;
   logic [2:0]  inflight_o;
   modport master (
      output id_valid_i, id_reg1_re_i, id_reg2_re_i, id_reg1_addr_i, id_reg2_addr_i,
             id_we_i, id_waddr_i, retire_i, wb_we_i, wb_waddr_i, flush_i, drain_req_i,
      input  issue_o, stall_id_o, drain_done_o, pending_o, inflight_o
   );
   modport slave (
      input  id_valid_i, id_reg1_re_i, id_reg2_re_i, id_reg1_addr_i, id_reg2_addr_i,
             id_we_i, id_waddr_i, retire_i, wb_we_i, wb_waddr_i, flush_i, drain_req_i,
      output issue_o, stall_id_o, drain_done_o, pending_o, inflight_o
   );
endinterface

// File: rtl/id_scoreboard.sv
// id_scoreboard: pending-write scoreboard gating decode issue, with inflight limit and RUN/DRAIN quiesce.
// Define ID_SB_WB_BYPASS_EN to let a register retiring this cycle stop counting as a hazard.
module id_scoreboard #(
   parameter int MAX_INFLIGHT = 4
) (
   input logic            clk,
   input logic            rst,
   id_scoreboard_if.slave sb
);
   typedef enum logic {RUN, DRAIN} state_e;
   localparam logic [2:0] MAX = 3'(MAX_INFLIGHT);
   state_e      state_q, state_d;
   logic [31:0] pending_q, pending_d, set_m, clr_m, chk_m;
   logic [2:0]  inflight_q, inflight_d;
   logic        hazard, full, issue;
   always_comb begin
      clr_m = (sb.retire_i && sb.wb_we_i) ? 32'd1 << sb.wb_waddr_i : '0;
`ifdef ID_SB_WB_BYPASS_EN
      chk_m = pending_q & ~clr_m;
`else
      chk_m = pending_q;
`endif
      hazard = (sb.id_reg1_re_i && chk_m[sb.id_reg1_addr_i]) ||
               (sb.id_reg2_re_i && chk_m[sb.id_reg2_addr_i]) ||
               (sb.id_we_i && chk_m[sb.id_waddr_i]);
      full = inflight_q == MAX && !sb.retire_i;
      issue = !rst && sb.id_valid_i && !hazard && !full && state_q == RUN && !sb.flush_i;
      set_m = (issue && sb.id_we_i) ? 32'd1 << sb.id_waddr_i : '0;
      // set after clear so a same-cycle set wins; bit 0 is never tracked
      pending_d = sb.flush_i ? '0 : ((pending_q & ~clr_m) | set_m) & ~32'd1;
      inflight_d = sb.flush_i ? '0 :
                   (issue && !sb.retire_i) ? inflight_q + 3'd1 :
                   (!issue && sb.retire_i && inflight_q != 3'd0) ? inflight_q - 3'd1 :
                   inflight_q;
      state_d = sb.flush_i ? state_q : sb.drain_req_i ? DRAIN : RUN;
      sb.issue_o = issue;
      sb.stall_id_o = !rst && sb.id_valid_i && !issue && !sb.flush_i;
      sb.drain_done_o = !rst && state_q == DRAIN && inflight_q == 3'd0 && pending_q == '0;
      sb.pending_o = pending_q;
      sb.inflight_o = inflight_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pending_q <= '0;
         inflight_q <= '0;
      end else begin
         state_q <= state_d;
         pending_q <= pending_d;
         inflight_q <= inflight_d;
      end
   end
endmodule
